// File: rtl/mlu_serial_pkg.sv
// mlu_serial common package: MLU op encodings and sequencer states.
// Shared by the slice, the interface and the top.
package mlu_serial_pkg;

  typedef enum logic [2:0] {
    MLU_ADD  = 3'd0,
    MLU_SUB  = 3'd1,
    MLU_AND  = 3'd2,
    MLU_OR   = 3'd3,
    MLU_XOR  = 3'd4,
    MLU_NOT  = 3'd5,
    MLU_ANOT = 3'd6,
    MLU_NOP1 = 3'd7
  } mlu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } mlu_state_e;

  function automatic logic is_arith(mlu_op_e op);
    return (op == MLU_ADD) || (op == MLU_SUB);
  endfunction

endpackage

// File: rtl/mlu_serial_if.sv
// mlu_serial request/result bundle.
// master drives the request, slave is the serial MLU.
interface mlu_serial_if #(
  parameter int WIDTH = 32
);
  import mlu_serial_pkg::*;

  logic             START;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  mlu_op_e          OP;
  logic             C_IN;
  logic             READY;
  logic             DONE;
  logic [WIDTH-1:0] OUT;
  logic             Z;
  logic             C;
  logic             N;
  logic             V;

  modport master (
    output START, A, B, OP, C_IN,
    input  READY, DONE, OUT, Z, C, N, V
  );

  modport slave (
    input  START, A, B, OP, C_IN,
    output READY, DONE, OUT, Z, C, N, V
  );

endinterface

// File: rtl/mlu_serial_slice.sv
// mlu_serial_slice: one combinational SLICE_W-bit MLU slice.
// Carry outputs are zero for logic ops so the ripple register clears.
module mlu_serial_slice
  import mlu_serial_pkg::*;
#(
  parameter int SLICE_W = 4
) (
  input  logic [SLICE_W-1:0] a_i,
  input  logic [SLICE_W-1:0] b_i,
  input  mlu_op_e            op_i,
  input  logic               cin_i,
  output logic [SLICE_W-1:0] y_o,
  output logic               cout_o,
  output logic               cmsb_o,
  output logic               zero_o
);

  logic               arith;
  logic [SLICE_W-1:0] bx;
  logic [SLICE_W:0]   sum;

  always_comb begin
    arith = is_arith(op_i);
    bx    = (op_i == MLU_SUB) ? ~b_i : b_i;
    sum   = {1'b0, a_i} + {1'b0, bx}
          + {{SLICE_W{1'b0}}, cin_i};
    y_o   = '0;
    unique case (op_i)
      MLU_ADD,
      MLU_SUB:  y_o = sum[SLICE_W-1:0];
      MLU_AND:  y_o = a_i & b_i;
      MLU_OR:   y_o = a_i | b_i;
      MLU_XOR:  y_o = a_i ^ b_i;
      MLU_NOT:  y_o = ~a_i;
      MLU_ANOT: y_o = a_i & ~b_i;
      MLU_NOP1: y_o = '0;
      default:  y_o = '0;
    endcase
    cout_o = arith & sum[SLICE_W];
    // carry into MSB recovered from the MSB sum bit
    cmsb_o = arith & (sum[SLICE_W-1]
           ^ a_i[SLICE_W-1] ^ bx[SLICE_W-1]);
    zero_o = (y_o == '0);
  end

endmodule

// File: rtl/mlu_serial.sv
// mlu_serial: slice-serial MLU, LSB slice first, start/done handshake.
// Optional signed overflow flag V: define MLU_OVERFLOW_EN.
module mlu_serial
  import mlu_serial_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SLICE_W = 4
) (
  input logic          CLK,
  input logic          N_RST,
  mlu_serial_if.slave  bus
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  mlu_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  mlu_op_e          op_q, op_d;
  logic             cin_q, cin_d;
  logic             cy_q, cy_d;
  logic [CW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             z_q, z_d;
  logic             c_q, c_d;

  logic [SLICE_W-1:0] s_a, s_b, s_y;
  logic               s_cout, s_cmsb, s_zero;
  logic               last;

  assign last = (idx_q == CW'(NSLICE - 1));
  assign s_a  = a_q[int'(idx_q)*SLICE_W +: SLICE_W];
  assign s_b  = b_q[int'(idx_q)*SLICE_W +: SLICE_W];

  mlu_serial_slice #(
    .SLICE_W (SLICE_W)
  ) u_slice (
    .a_i    (s_a),
    .b_i    (s_b),
    .op_i   (op_q),
    .cin_i  (cy_q),
    .y_o    (s_y),
    .cout_o (s_cout),
    .cmsb_o (s_cmsb),
    .zero_o (s_zero)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.START) state_d = RUN;
      RUN:     if (last) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    op_d  = op_q;
    cin_d = cin_q;
    cy_d  = cy_q;
    idx_d = idx_q;
    out_d = out_q;
    z_d   = z_q;
    c_d   = c_q;
    unique case (state_q)
      IDLE: begin
        if (bus.START) begin
          a_d   = bus.A;
          b_d   = bus.B;
          op_d  = bus.OP;
          cin_d = bus.C_IN;
          cy_d  = bus.C_IN;
          idx_d = '0;
          out_d = '0;
          z_d   = 1'b1;
        end
      end
      RUN: begin
        out_d[int'(idx_q)*SLICE_W +: SLICE_W] = s_y;
        cy_d  = s_cout;
        z_d   = z_q & s_zero;
        idx_d = idx_q + CW'(1);
        if (last) c_d = s_cout;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge N_RST) begin
    if (!N_RST) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= MLU_NOP1;
      cin_q   <= 1'b0;
      cy_q    <= 1'b0;
      idx_q   <= '0;
      out_q   <= '0;
      z_q     <= 1'b1;
      c_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      cin_q   <= cin_d;
      cy_q    <= cy_d;
      idx_q   <= idx_d;
      out_q   <= out_d;
      z_q     <= z_d;
      c_q     <= c_d;
    end
  end

  assign bus.READY = (state_q == IDLE);
  assign bus.DONE  = (state_q == FIN);
  assign bus.OUT   = out_q;
  assign bus.Z     = z_q;
  assign bus.C     = c_q;
  assign bus.N     = out_q[WIDTH-1];

`ifdef MLU_OVERFLOW_EN
  logic v_q, v_d;

  always_comb begin
    v_d = v_q;
    if (state_q == IDLE && bus.START) v_d = 1'b0;
    if (state_q == RUN && last) v_d = s_cmsb ^ s_cout;
  end

  always_ff @(posedge CLK or negedge N_RST) begin
    if (!N_RST) v_q <= 1'b0;
    else        v_q <= v_d;
  end

  assign bus.V = v_q;
`else
  logic unused_cmsb;
  assign unused_cmsb = s_cmsb;
  assign bus.V = 1'b0;
`endif

`ifndef SYNTHESIS
  function automatic logic [WIDTH-1:0] mlu_ref(
    input mlu_op_e          op,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic             ci
  );
    logic [WIDTH-1:0] r;
    r = '0;
    unique case (op)
      MLU_ADD:  r = a + b + WIDTH'(ci);
      MLU_SUB:  r = a + ~b + WIDTH'(ci);
      MLU_AND:  r = a & b;
      MLU_OR:   r = a | b;
      MLU_XOR:  r = a ^ b;
      MLU_NOT:  r = ~a;
      MLU_ANOT: r = a & ~b;
      MLU_NOP1: r = '0;
      default:  r = '0;
    endcase
    return r;
  endfunction

  a_fin_result: assert property (
    @(posedge CLK) disable iff (!N_RST)
    (state_q == FIN) |->
      (out_q == mlu_ref(op_q, a_q, b_q, cin_q))
      && (z_q == (out_q == '0))
  );

  a_sub_cin: assert property (
    @(posedge CLK) disable iff (!N_RST)
    (state_q == IDLE && bus.START && bus.OP == MLU_SUB)
      |-> bus.C_IN
  );
`endif

endmodule

// File: tb/tb_mlu_serial.sv
// tb_mlu_serial: directed vectors for mlu_serial (32/4 and 8/4).
// Expected results hand-computed; V expectation follows MLU_OVERFLOW_EN.
module tb_mlu_serial;
  import mlu_serial_pkg::*;

`ifdef MLU_OVERFLOW_EN
  localparam logic OVF = 1'b1;
`else
  localparam logic OVF = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;

  mlu_serial_if #(.WIDTH(32)) bus ();
  mlu_serial_if #(.WIDTH(8))  bus8 ();

  mlu_serial #(
    .WIDTH   (32),
    .SLICE_W (4)
  ) u_dut (
    .CLK   (clk),
    .N_RST (rst_n),
    .bus   (bus.slave)
  );

  mlu_serial #(
    .WIDTH   (8),
    .SLICE_W (4)
  ) u_dut8 (
    .CLK   (clk),
    .N_RST (rst_n),
    .bus   (bus8.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op32(
    input  mlu_op_e     op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        ci,
    output int          lat
  );
    int k;
    k = 0;
    while (!bus.READY && k < 40) begin
      tick();
      k++;
    end
    bus.START = 1'b1;
    bus.OP    = op;
    bus.A     = a;
    bus.B     = b;
    bus.C_IN  = ci;
    lat       = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      bus.START = 1'b0;
      if (bus.DONE) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic logic_op(
    input string       tag,
    input mlu_op_e     op,
    input logic [31:0] exp
  );
    int lat;
    op32(op, 32'hF0F0A5A5, 32'hFF00FF00, 1'b0, lat);
    chk({tag, "_lat"}, 64'(lat), 64'd9);
    chk({tag, "_out"}, 64'(bus.OUT), 64'(exp));
    chk({tag, "_c"}, 64'(bus.C), 64'd0);
    chk({tag, "_z"}, 64'(bus.Z), 64'(exp == 32'd0));
  endtask

  initial begin
    int   lat;
    int   d1, d2, dn;
    logic [31:0] o1, o2;
    logic r10, r11;

    n_chk      = 0;
    n_pass     = 0;
    rst_n      = 1'b0;
    bus.START  = 1'b0;
    bus.A      = '0;
    bus.B      = '0;
    bus.OP     = MLU_NOP1;
    bus.C_IN   = 1'b0;
    bus8.START = 1'b0;
    bus8.A     = '0;
    bus8.B     = '0;
    bus8.OP    = MLU_NOP1;
    bus8.C_IN  = 1'b0;

    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("rst_ready", 64'(bus.READY), 64'd1);
    chk("rst_done", 64'(bus.DONE), 64'd0);
    chk("rst_out", 64'(bus.OUT), 64'd0);
    chk("rst_z", 64'(bus.Z), 64'd1);
    chk("rst_c", 64'(bus.C), 64'd0);
    chk("rst_n", 64'(bus.N), 64'd0);
    chk("rst_v", 64'(bus.V), 64'd0);

    op32(MLU_ADD, 32'hFFFFFFFF, 32'h1, 1'b0, lat);
    chk("add_wrap_lat", 64'(lat), 64'd9);
    chk("add_wrap_out", 64'(bus.OUT), 64'd0);
    chk("add_wrap_z", 64'(bus.Z), 64'd1);
    chk("add_wrap_c", 64'(bus.C), 64'd1);
    chk("add_wrap_n", 64'(bus.N), 64'd0);
    chk("add_wrap_v", 64'(bus.V), 64'd0);
    tick();
    chk("done_pulse", 64'(bus.DONE), 64'd0);
    chk("hold_out", 64'(bus.C), 64'd1);

    op32(MLU_SUB, 32'h5, 32'h7, 1'b1, lat);
    chk("sub57_out", 64'(bus.OUT), 64'hFFFFFFFE);
    chk("sub57_n", 64'(bus.N), 64'd1);
    chk("sub57_z", 64'(bus.Z), 64'd0);
    chk("sub57_c", 64'(bus.C), 64'd0);

    op32(MLU_SUB, 32'h7, 32'h5, 1'b1, lat);
    chk("sub75_out", 64'(bus.OUT), 64'h2);
    chk("sub75_c", 64'(bus.C), 64'd1);
    chk("sub75_n", 64'(bus.N), 64'd0);

    op32(MLU_ADD, 32'h7FFFFFFF, 32'h1, 1'b0, lat);
    chk("ovf_out", 64'(bus.OUT), 64'h80000000);
    chk("ovf_n", 64'(bus.N), 64'd1);
    chk("ovf_v", 64'(bus.V), 64'(OVF));
    chk("ovf_c", 64'(bus.C), 64'd0);

    logic_op("and", MLU_AND, 32'hF000A500);
    logic_op("or", MLU_OR, 32'hFFF0FFA5);
    logic_op("xor", MLU_XOR, 32'h0FF05AA5);
    logic_op("not", MLU_NOT, 32'h0F0F5A5A);
    logic_op("anot", MLU_ANOT, 32'h00F000A5);
    logic_op("nop1", MLU_NOP1, 32'h0);
    chk("nop1_v", 64'(bus.V), 64'd0);

    // START held high; operands change mid-RUN
    tick();
    bus.START = 1'b1;
    bus.OP    = MLU_ADD;
    bus.A     = 32'h1;
    bus.B     = 32'h2;
    bus.C_IN  = 1'b0;
    d1 = -1;
    d2 = -1;
    o1 = '0;
    o2 = '0;
    r10 = 1'b0;
    r11 = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (i == 3) begin
        bus.A = 32'h100;
        bus.B = 32'h200;
      end
      if (i == 10) r10 = bus.READY;
      if (i == 11) r11 = bus.READY;
      if (bus.DONE) begin
        if (d1 < 0) begin
          d1 = i;
          o1 = bus.OUT;
        end else if (d2 < 0) begin
          d2 = i;
          o2 = bus.OUT;
        end
      end
    end
    bus.START = 1'b0;
    chk("hs_done1", 64'(d1), 64'd9);
    chk("hs_out1", 64'(o1), 64'h3);
    chk("hs_ready_idle", 64'(r10), 64'd1);
    chk("hs_ready_busy", 64'(r11), 64'd0);
    chk("hs_done2", 64'(d2), 64'd19);
    chk("hs_out2", 64'(o2), 64'h300);

    // reset pulse in the middle of slice 4
    lat = 0;
    while (!bus.READY && lat < 40) begin
      tick();
      lat++;
    end
    bus.START = 1'b1;
    bus.OP    = MLU_ADD;
    bus.A     = 32'h12345678;
    bus.B     = 32'h11111111;
    tick();
    bus.START = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    chk("abort_ready", 64'(bus.READY), 64'd1);
    chk("abort_out", 64'(bus.OUT), 64'd0);
    chk("abort_z", 64'(bus.Z), 64'd1);
    chk("abort_c", 64'(bus.C), 64'd0);
    chk("abort_done", 64'(bus.DONE), 64'd0);
    tick();
    rst_n = 1'b1;
    dn = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.DONE) dn++;
    end
    chk("abort_no_done", 64'(dn), 64'd0);
    op32(MLU_ADD, 32'h12345678, 32'h11111111, 1'b0, lat);
    chk("post_rst_lat", 64'(lat), 64'd9);
    chk("post_rst_out", 64'(bus.OUT), 64'h23456789);
    tick();

    // 8-bit instance: two slices
    bus8.START = 1'b1;
    bus8.OP    = MLU_ADD;
    bus8.A     = 8'h80;
    bus8.B     = 8'h80;
    bus8.C_IN  = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      bus8.START = 1'b0;
      if (bus8.DONE) begin
        lat = i;
        break;
      end
    end
    chk("w8_lat", 64'(lat), 64'd3);
    chk("w8_out", 64'(bus8.OUT), 64'h0);
    chk("w8_c", 64'(bus8.C), 64'd1);
    chk("w8_z", 64'(bus8.Z), 64'd1);
    chk("w8_v", 64'(bus8.V), 64'(OVF));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
